// File: rtl/alarm_clock_core.sv
// Purpose : 24h time-of-day clock with NUM_ALARMS alarm slots, snooze/dismiss FSM, tone output and 12h BCD display.
// Latency : time/slot writes take effect on the next edge; display digits are combinational from the time register.
// Backpressure: none; all inputs are single-cycle strobes that are always accepted (or ignored when out of range).
//
// Ports:
//   CLK100MHZ, CPU_RESETN          clock, async active-low reset
//   set_time/set_hour/set_min      load time of day (seconds cleared)
//   alm_wr/alm_idx/alm_hour/alm_min/alm_en   write one alarm slot
//   snooze, dismiss                user strobes while an alarm is active
//   hourten/hour/minten/min/pm     12h BCD display
//   sec_tick                       one-cycle pulse per second
//   ringing/alarm_id/alarm_sound   alarm status and square-wave tone
module alarm_clock_core #(
    parameter int CLK_HZ       = 100000000,
    parameter int TICK_DIV     = 100000000,
    parameter int NUM_ALARMS   = 4,
    parameter int SNOOZE_MIN   = 9,
    parameter int RING_MAX_MIN = 5,
    parameter int TONE_DIV     = 50000
) (
    input  logic       CLK100MHZ,
    input  logic       CPU_RESETN,
    input  logic       set_time,
    input  logic [4:0] set_hour,
    input  logic [5:0] set_min,
    input  logic       alm_wr,
    input  logic [2:0] alm_idx,
    input  logic [4:0] alm_hour,
    input  logic [5:0] alm_min,
    input  logic       alm_en,
    input  logic       snooze,
    input  logic       dismiss,
    output logic [3:0] hourten,
    output logic [3:0] hour,
    output logic [3:0] minten,
    output logic [3:0] min,
    output logic       pm,
    output logic       sec_tick,
    output logic       ringing,
    output logic [2:0] alarm_id,
    output logic       alarm_sound
);

    localparam int PW = $clog2(TICK_DIV);
    localparam int TW = (TONE_DIV > 1) ? $clog2(TONE_DIV) : 1;
    localparam logic [PW-1:0] PRESC_END = PW'(TICK_DIV - 1);
    localparam logic [TW-1:0] TONE_END  = TW'(TONE_DIV - 1);
    localparam logic [5:0]    RING_LAST = 6'(RING_MAX_MIN - 1);

    // Elaboration-time guard against out-of-range parameters.
    if (CLK_HZ < 1 || TICK_DIV < 2 || NUM_ALARMS < 1 || NUM_ALARMS > 8 ||
        SNOOZE_MIN < 1 || SNOOZE_MIN > 59 || RING_MAX_MIN < 1 || RING_MAX_MIN > 59 ||
        TONE_DIV < 1) begin : g_param_check
        $error("alarm_clock_core: parameter out of range");
    end

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RINGING = 2'd1,
        SNOOZED = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // Time of day
    // ------------------------------------------------------------------
    logic [PW-1:0] presc_q;
    logic [4:0]    hr_q;
    logic [5:0]    mn_q;
    logic [5:0]    sc_q;

    logic       set_ok;
    logic       presc_end;
    logic       tick;
    logic       min_bnd;
    logic [4:0] nxt_hr;
    logic [5:0] nxt_mn;

    assign set_ok    = set_time && (set_hour <= 5'd23) && (set_min <= 6'd59);
    assign presc_end = (presc_q == PRESC_END);
    // A valid time load swallows any tick landing on the same cycle.
    assign tick      = presc_end && !set_ok;
    assign min_bnd   = tick && (sc_q == 6'd59);

    // Time the clock will show after this minute boundary.
    always_comb begin
        nxt_mn = (mn_q == 6'd59) ? 6'd0 : mn_q + 6'd1;
        nxt_hr = hr_q;
        if (mn_q == 6'd59) begin
            nxt_hr = (hr_q == 5'd23) ? 5'd0 : hr_q + 5'd1;
        end
    end

    always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            presc_q  <= '0;
            hr_q     <= '0;
            mn_q     <= '0;
            sc_q     <= '0;
            sec_tick <= 1'b0;
        end else if (set_ok) begin
            presc_q  <= '0;
            hr_q     <= set_hour;
            mn_q     <= set_min;
            sc_q     <= '0;
            sec_tick <= 1'b0;
        end else begin
            sec_tick <= presc_end;
            if (presc_end) begin
                presc_q <= '0;
                sc_q    <= (sc_q == 6'd59) ? 6'd0 : sc_q + 6'd1;
                if (min_bnd) begin
                    mn_q <= nxt_mn;
                    hr_q <= nxt_hr;
                end
            end else begin
                presc_q <= presc_q + PW'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // Alarm slots; an alm_idx beyond the last slot matches no slot.
    // ------------------------------------------------------------------
    logic [4:0] slot_hr [NUM_ALARMS];
    logic [5:0] slot_mn [NUM_ALARMS];
    logic       slot_en [NUM_ALARMS];
    logic       alm_ok;

    assign alm_ok = alm_wr && (alm_hour <= 5'd23) && (alm_min <= 6'd59);

    always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            for (int i = 0; i < NUM_ALARMS; i++) begin
                slot_hr[i] <= '0;
                slot_mn[i] <= '0;
                slot_en[i] <= 1'b0;
            end
        end else begin
            for (int i = 0; i < NUM_ALARMS; i++) begin
                if (alm_ok && (alm_idx == 3'(i))) begin
                    slot_hr[i] <= alm_hour;
                    slot_mn[i] <= alm_min;
                    slot_en[i] <= alm_en;
                end
            end
        end
    end

    // Descending scan so the lowest matching index is the one left standing.
    logic       hit;
    logic [2:0] hit_id;

    always_comb begin
        hit    = 1'b0;
        hit_id = 3'd0;
        for (int i = NUM_ALARMS - 1; i >= 0; i--) begin
            if (slot_en[i] && (slot_hr[i] == nxt_hr) && (slot_mn[i] == nxt_mn)) begin
                hit    = 1'b1;
                hit_id = 3'(i);
            end
        end
    end

    // ------------------------------------------------------------------
    // Snooze wake time: current time + SNOOZE_MIN, hour wraps 23->0.
    // ------------------------------------------------------------------
    logic [6:0] snz_sum;
    logic [4:0] wake_hr_d;
    logic [5:0] wake_mn_d;

    always_comb begin
        snz_sum   = {1'b0, mn_q} + 7'(SNOOZE_MIN);
        wake_hr_d = hr_q;
        wake_mn_d = snz_sum[5:0];
        if (snz_sum >= 7'd60) begin
            wake_mn_d = 6'(snz_sum - 7'd60);
            wake_hr_d = (hr_q == 5'd23) ? 5'd0 : hr_q + 5'd1;
        end
    end

    // ------------------------------------------------------------------
    // Alarm FSM
    // ------------------------------------------------------------------
    state_t     state_q, state_d;
    logic       ring_clr;
    logic       wake_ld;
    logic       id_ld;
    logic [5:0] ring_cnt_q;
    logic [4:0] wake_hr_q;
    logic [5:0] wake_mn_q;

    always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        ring_clr = 1'b0;
        wake_ld  = 1'b0;
        id_ld    = 1'b0;
        case (state_q)
            IDLE: begin
                if (min_bnd && hit) begin
                    state_d  = RINGING;
                    ring_clr = 1'b1;
                    id_ld    = 1'b1;
                end
            end
            RINGING: begin
                // dismiss outranks snooze when both arrive together
                if (dismiss) begin
                    state_d = IDLE;
                end else if (snooze) begin
                    state_d = SNOOZED;
                    wake_ld = 1'b1;
                end else if (min_bnd && (ring_cnt_q == RING_LAST)) begin
                    state_d = IDLE;
                end
            end
            SNOOZED: begin
                if (dismiss) begin
                    state_d = IDLE;
                end else if (min_bnd && (nxt_hr == wake_hr_q) && (nxt_mn == wake_mn_q)) begin
                    state_d  = RINGING;
                    ring_clr = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Ring-minute counter, wake time and fired slot id.
    always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            ring_cnt_q <= '0;
            wake_hr_q  <= '0;
            wake_mn_q  <= '0;
            alarm_id   <= '0;
        end else begin
            if (ring_clr) begin
                ring_cnt_q <= '0;
            end else if ((state_q == RINGING) && min_bnd) begin
                ring_cnt_q <= ring_cnt_q + 6'd1;
            end
            if (wake_ld) begin
                wake_hr_q <= wake_hr_d;
                wake_mn_q <= wake_mn_d;
            end
            if (id_ld) begin
                alarm_id <= hit_id;
            end
        end
    end

    // Tone: starts low on entry to RINGING, toggles every TONE_DIV cycles,
    // and drops to 0 on the edge that leaves RINGING.
    logic [TW-1:0] tone_cnt_q;

    always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            tone_cnt_q  <= '0;
            alarm_sound <= 1'b0;
        end else if ((state_q == RINGING) && (state_d == RINGING)) begin
            if (tone_cnt_q == TONE_END) begin
                tone_cnt_q  <= '0;
                alarm_sound <= ~alarm_sound;
            end else begin
                tone_cnt_q <= tone_cnt_q + TW'(1);
            end
        end else begin
            tone_cnt_q  <= '0;
            alarm_sound <= 1'b0;
        end
    end

    assign ringing = (state_q == RINGING);

    // ------------------------------------------------------------------
    // 12h BCD display: 0 -> 12 AM, 12 -> 12 PM, 13..23 -> 1..11 PM
    // ------------------------------------------------------------------
    logic [4:0] h12;

    always_comb begin
        if (hr_q == 5'd0) begin
            h12 = 5'd12;
        end else if (hr_q > 5'd12) begin
            h12 = hr_q - 5'd12;
        end else begin
            h12 = hr_q;
        end
        hourten = (h12 >= 5'd10) ? 4'd1 : 4'd0;
        hour    = (h12 >= 5'd10) ? 4'(h12 - 5'd10) : 4'(h12);
        minten  = 4'(mn_q / 6'd10);
        min     = 4'(mn_q % 6'd10);
        pm      = (hr_q >= 5'd12);
    end

endmodule
